button_debounce: RTL and testbench
==================================

# button_debounce

Multi-channel push-button conditioner for the board-level calculator and later lab top-levels. Each raw button input is synchronized into the `clk` domain and filtered by a per-channel counter state machine. The block produces a clean debounced level plus single-cycle press and release strobes. The calculator top-level uses the `btn_db` levels to select the ALU operation and the `btn_press` strobe of the down button to load the accumulator.

## Interface

Parameters:
- `NUM_BTN`, default 5: number of independent channels.
- `DEBOUNCE_CYCLES`, default 500000: stable-sample count required before a change is accepted. This is 5 ms at 100 MHz. Legal range is ≥ 2.

Ports:
- `clk`, input, 1 bit: single system clock; all logic runs on its rising edge.
- `rst_n`, input, 1 bit: reset. **Synchronous, active-low.**
- `btn_in`, input, `NUM_BTN` bits: raw, asynchronous, bouncing button levels.
- `btn_db`, output, `NUM_BTN` bits: debounced level, registered.
- `btn_press`, output, `NUM_BTN` bits: one-cycle pulse on each accepted 0→1 change, registered.
- `btn_release`, output, `NUM_BTN` bits: one-cycle pulse on each accepted 1→0 change, registered.

## Operation

- **Synchronizer:** each channel has a 2-flop synchronizer (`sync1` → `sync2`). Only `sync2` is seen by the FSM.
- **FSM states:** each channel runs its own FSM with states `DB_LOW`, `DB_WAIT_HIGH`, `DB_HIGH`, `DB_WAIT_LOW`.
- **Counter:** each channel has a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)` bits.
- **Transitions**, evaluated every edge when `rst_n` = 1:
  - `DB_LOW`: if `sync2` = 1, go to `DB_WAIT_HIGH` and set `cnt` ← 0. Otherwise stay.
  - `DB_WAIT_HIGH`:
    - If `sync2` = 0, return to `DB_LOW` (bounce rejected, no strobe).
    - Else if `cnt` == `DEBOUNCE_CYCLES`−1, go to `DB_HIGH` and assert `btn_press` for the next cycle.
    - Else `cnt` ← `cnt`+1.
  - `DB_HIGH`: mirror of `DB_LOW`. If `sync2` = 0, go to `DB_WAIT_LOW` and set `cnt` ← 0.
  - `DB_WAIT_LOW`: mirror of `DB_WAIT_HIGH`.
    - `sync2` = 1 returns to `DB_HIGH` with no strobe.
    - Terminal count goes to `DB_LOW` and asserts `btn_release`.
- **Acceptance rule:** a change is accepted only after `DEBOUNCE_CYCLES`+1 consecutive identical `sync2` samples. Any single opposite sample restarts the qualification from scratch.
- **Level output:** `btn_db` = 1 exactly while the state is `DB_HIGH` or `DB_WAIT_LOW`. A bounce during release never drops the level.
- **Counter behaviour:** `cnt` never wraps. It is held, not incremented, in `DB_LOW` and `DB_HIGH`.
- **Channel independence:** channels share nothing but `clk` and `rst_n`. Simultaneous presses on several channels produce strobes in the same cycle.
- **Reset:** `rst_n` = 0 on an edge forces, for every channel:
  - `sync1`, `sync2`, `cnt` to 0;
  - state to `DB_LOW`;
  - `btn_db`, `btn_press`, `btn_release` to 0.
- **Reset mid-operation:** reset mid-qualification discards the partial count with no strobe. A button held through reset release is reported as a fresh press after the normal latency.

## Timing

- **Press latency:** if `btn_in` rises and stays stable before edge k, `btn_db` and `btn_press` go high after edge k+`DEBOUNCE_CYCLES`+2.
- **Release latency:** identical in the release direction.
- **Strobe width:** `btn_press` and `btn_release` are exactly one cycle wide. At most one strobe per channel can occur in any `DEBOUNCE_CYCLES`+1 cycle window.
- **Reset values:** all outputs are 0 in the cycle after any edge with `rst_n` = 0.

## Structure

- **Shared package `debounce_pkg`:** holds the `db_state_t` enum (2-bit: `DB_LOW`, `DB_WAIT_HIGH`, `DB_HIGH`, `DB_WAIT_LOW`). It also holds the 100 MHz default-count constant `DB_CYCLES_5MS`.
- **Sub-module `debounce_ch`:** one channel, containing the synchronizer, FSM, counter and registered outputs. `button_debounce` instantiates `NUM_BTN` copies in a generate loop.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4 and `NUM_BTN`=5.

1. **Reset:** hold `rst_n`=0 for 3 cycles with `btn_in`=5'b11111 → all outputs 0 throughout. After release, all five `btn_press` pulse together exactly 6 cycles later.
2. **Clean press:** `btn_in[0]` 0→1 and held → `btn_db[0]` rises 6 cycles after the first sampling edge. `btn_press[0]` is high for exactly 1 cycle. `btn_release` stays 0.
3. **Bounce rejection:** `btn_in[1]` pattern 1,1,0,1,1,1,0 (one value per cycle), then 0 → no strobe and `btn_db[1]` stays 0.
   - The same glitch pattern while the channel is high → `btn_db[1]` stays 1 and `btn_release[1]` stays 0.
4. **Release:** from the stable-high state, drop `btn_in[2]` and hold → `btn_db[2]` falls 6 cycles later, with a single `btn_release[2]` pulse.
5. **Reset mid-qualification:** assert `rst_n`=0 for 1 cycle, 3 cycles into a qualifying press → no `btn_press` from the interrupted attempt. A fresh press is reported 6 cycles after reset release.
6. **Independence:** `btn_in[3]` and `btn_in[4]` rise in the same cycle; channel 0 bounces continuously → channels 3 and 4 strobe together, channel 0 never does.

Source files
------------

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared state encoding and default count for the debouncer.
// Revision    : 1.0  initial release
// ============================================================================
package debounce_pkg;

  typedef enum logic [1:0] {
    DB_LOW       = 2'd0,
    DB_WAIT_HIGH = 2'd1,
    DB_HIGH      = 2'd2,
    DB_WAIT_LOW  = 2'd3
  } db_state_t;

  // 5 ms at a 100 MHz system clock
  localparam int DB_CYCLES_5MS = 500000;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : debounce_ch
// Description : One button channel: 2-flop synchronizer, qualification FSM,
//               saturating counter and registered level/press/release outputs.
// Revision    : 1.0  initial release
// ============================================================================
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DB_CYCLES_5MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_db,
  output logic o_press,
  output logic o_release
);

  localparam int            c_CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_TERM = c_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  logic            r_sync1;
  logic            r_sync2;
  db_state_t       r_state;
  logic [c_CW-1:0] r_cnt;
  logic            r_db;
  logic            r_press;
  logic            r_release;

  db_state_t       w_state_nxt;
  logic [c_CW-1:0] w_cnt_nxt;
  logic            w_db_nxt;
  logic            w_press_nxt;
  logic            w_release_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= DB_LOW;
      r_cnt     <= '0;
      r_db      <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_db      <= w_db_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // The counter only advances in the WAIT states and stops at terminal count
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      DB_LOW: begin
        if (r_sync2) begin
          w_state_nxt = DB_WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      DB_WAIT_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = DB_LOW;
        end else if (r_cnt == c_TERM) begin
          w_state_nxt = DB_HIGH;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_ONE;
        end
      end
      DB_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = DB_WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end
      DB_WAIT_LOW: begin
        if (r_sync2) begin
          w_state_nxt = DB_HIGH;
        end else if (r_cnt == c_TERM) begin
          w_state_nxt   = DB_LOW;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_ONE;
        end
      end
      default: begin
        w_state_nxt = DB_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
    w_db_nxt = (w_state_nxt == DB_HIGH) || (w_state_nxt == DB_WAIT_LOW);
  end

  assign o_db      = r_db;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule : debounce_ch
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : NUM_BTN independent push-button debounce channels.
// Revision    : 1.0  initial release
// ============================================================================
module button_debounce
  import debounce_pkg::*;
#(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = DB_CYCLES_5MS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_db,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_btn     (btn_in[g]),
      .o_db      (btn_db[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g])
    );
  end

endmodule : button_debounce
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debounce
// Description : Scoreboard bench for button_debounce with a run-length model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_button_debounce;

  localparam int NB = 5;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_db;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  always #5 clk = ~clk;

  button_debounce #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .btn_db      (btn_db),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: a change is accepted once DC+1 consecutive sync samples disagree with the level
  logic [NB-1:0] m_s1, m_s2, m_lvl;
  int            m_run [NB];
  logic [3*NB-1:0] sb_q [$];

  int            ncyc;
  int            pc [NB], rc [NB], fp [NB], fr [NB];
  logic [NB-1:0] db_hi, db_lo;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ncyc  = 0;
    db_hi = '0;
    db_lo = '0;
    for (int i = 0; i < NB; i++) begin
      pc[i] = 0; rc[i] = 0; fp[i] = -1; fr[i] = -1;
    end
  endtask

  task automatic cyc(input logic [NB-1:0] b, input logic r);
    logic [NB-1:0]   ep, er;
    logic [3*NB-1:0] exp_v;
    btn_in = b;
    rst_n  = r;
    ep = '0;
    er = '0;
    if (!r) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DC + 1) begin
            m_lvl[i] = m_s2[i];
            m_run[i] = 0;
            if (m_s2[i]) ep[i] = 1'b1;
            else         er[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
    sb_q.push_back({m_lvl, ep, er});
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    check_val("outputs", {17'd0, btn_db, btn_press, btn_release}, {17'd0, exp_v});
    for (int i = 0; i < NB; i++) begin
      if (btn_press[i])   begin pc[i]++; if (fp[i] < 0) fp[i] = ncyc; end
      if (btn_release[i]) begin rc[i]++; if (fr[i] < 0) fr[i] = ncyc; end
    end
    db_hi = db_hi | btn_db;
    db_lo = db_lo | ~btn_db;
    ncyc++;
  endtask

  task automatic run(input logic [NB-1:0] b, input int n);
    for (int i = 0; i < n; i++) cyc(b, 1'b1);
  endtask

  initial begin
    logic [6:0] pat_lo, pat_hi;
    pat_lo = 7'b1101110;
    pat_hi = 7'b0010001;
    btn_in = '0;
    rst_n  = 1'b0;
    m_s1 = '0; m_s2 = '0; m_lvl = '0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
    clr();

    // Reset with all buttons held, then fresh press after release
    for (int i = 0; i < 3; i++) cyc(5'b11111, 1'b0);
    check_val("rst_db_seen", {27'd0, db_hi}, 32'd0);
    check_val("rst_outs", {17'd0, btn_db, btn_press, btn_release}, 32'd0);
    clr();
    run(5'b11111, 10);
    for (int i = 0; i < NB; i++) check_val("rst_press_lat", fp[i], 32'd6);
    run(5'b00000, 12);

    // Clean press on channel 0
    clr();
    run(5'b00001, 15);
    check_val("press_lat0", fp[0], 32'd6);
    check_val("press_cnt0", pc[0], 32'd1);
    check_val("rel_cnt0", rc[0], 32'd0);

    // Bounce rejection on channel 1, low then high
    clr();
    for (int i = 6; i >= 0; i--) cyc({3'b000, pat_lo[i], 1'b1}, 1'b1);
    run(5'b00001, 8);
    check_val("bounce_lo_press", pc[1], 32'd0);
    check_val("bounce_lo_db", {31'd0, db_hi[1]}, 32'd0);
    run(5'b00011, 12);
    clr();
    for (int i = 6; i >= 0; i--) cyc({3'b000, pat_hi[i], 1'b1}, 1'b1);
    run(5'b00011, 8);
    check_val("bounce_hi_rel", rc[1], 32'd0);
    check_val("bounce_hi_db", {31'd0, db_lo[1]}, 32'd0);

    // Release on channel 2
    run(5'b00111, 12);
    clr();
    run(5'b00011, 12);
    check_val("rel_lat2", fr[2], 32'd6);
    check_val("rel_cnt2", rc[2], 32'd1);

    // Reset three cycles into a qualifying press on channel 3
    run(5'b00000, 12);
    clr();
    run(5'b01000, 3);
    cyc(5'b01000, 1'b0);
    check_val("midq_press", pc[3], 32'd0);
    clr();
    run(5'b01000, 10);
    check_val("midq_fresh_lat", fp[3], 32'd6);
    check_val("midq_fresh_cnt", pc[3], 32'd1);

    // Channels 3/4 together while channel 0 chatters
    run(5'b00000, 12);
    clr();
    for (int i = 0; i < 20; i++) cyc({2'b11, 2'b00, 1'(i % 2)}, 1'b1);
    check_val("indep_lat3", fp[3], 32'd6);
    check_val("indep_lat4", fp[4], 32'd6);
    check_val("indep_press0", pc[0], 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_button_debounce
`default_nettype wire
